pulse_train_gen: RTL and testbench

Generates a burst of N clean, fixed-width output pulses from a single one-cycle trigger. It is the output-side counterpart of the rising-edge detector: the detector turns raw button activity into one-cycle pulses, and this block turns one-cycle pulses back into human-visible level activity. Typical use is driving an LED or a status pin with a blink code, for example pass/fail/lockout results from the authentication FSM. All outputs are registered.

---
 rtl/pulse_train_gen.sv | 115 +++++++++++
 tb/tb_pulse_train_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_train_gen.sv
`timescale 1ns/1ps
// pulse_train_gen: turns a one-cycle start into a burst of `count` fixed-width
// pulses (ON_CYCLES high, OFF_CYCLES low between pulses, no trailing gap).
// done pulses for one cycle when a burst ends or a zero-count start is taken.
// All outputs come straight from flops.
module pulse_train_gen #(
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 4,
  parameter int CNT_W      = 4,
  parameter int TIMER_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [TIMER_W-1:0] ON_LOAD   = TIMER_W'(ON_CYCLES);
  localparam logic [TIMER_W-1:0] OFF_LOAD  = TIMER_W'(OFF_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
  localparam logic [CNT_W-1:0]   REM_ONE   = CNT_W'(1);

  state_t             state, state_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic [CNT_W-1:0]   remaining, remaining_n;
  logic               done_n;
  logic               start_q;
  logic               accept;

  // A start held high across a whole burst must not retrigger in the done
  // cycle, so only a low-to-high transition of start counts as a request.
  assign accept = start & ~start_q;

  // Next-state, timer and remaining-count logic.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned, which would otherwise infer a latch.
    state_n     = state;
    timer_n     = timer;
    remaining_n = remaining;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (count == '0) begin
            done_n = 1'b1;
          end else begin
            remaining_n = count;
            timer_n     = ON_LOAD;
            state_n     = HIGH;
          end
        end
      end
      HIGH: begin
        if (timer == TIMER_ONE) begin
          if (remaining > REM_ONE) begin
            remaining_n = remaining - REM_ONE;
            timer_n     = OFF_LOAD;
            state_n     = LOW;
          end else begin
            remaining_n = '0;
            timer_n     = '0;
            done_n      = 1'b1;
            state_n     = IDLE;
          end
        end else begin
          timer_n = timer - TIMER_ONE;
        end
      end
      LOW: begin
        if (timer == TIMER_ONE) begin
          timer_n = ON_LOAD;
          state_n = HIGH;
        end else begin
          timer_n = timer - TIMER_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and registered outputs; outputs decode the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      timer     <= '0;
      remaining <= '0;
      start_q   <= 1'b0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      state     <= state_n;
      timer     <= timer_n;
      remaining <= remaining_n;
      start_q   <= start;
      pulse_out <= (state_n == HIGH);
      busy      <= (state_n != IDLE);
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
`timescale 1ns/1ps
// Bench for pulse_train_gen: instance A uses ON=4/OFF=4, instance B ON=2/OFF=3.
// Both share start/count/reset; each scenario observes one of them.
module tb_pulse_train_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] count = 4'd0;
  logic       po_a, busy_a, done_a;
  logic       po_b, busy_b, done_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pulse_train_gen u_a (
    .clk(clk), .reset(reset), .start(start), .count(count),
    .pulse_out(po_a), .busy(busy_a), .done(done_a)
  );

  pulse_train_gen #(.ON_CYCLES(2), .OFF_CYCLES(3), .CNT_W(4), .TIMER_W(8)) u_b (
    .clk(clk), .reset(reset), .start(start), .count(count),
    .pulse_out(po_b), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    logic [3:0] cnt;
    bit         sel_b;  // 0: instance A (4/4), 1: instance B (2/3)
    int         last;   // hand-computed last busy cycle after start edge
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [2:0] outs(input bit sel_b);
    return sel_b ? {po_b, busy_b, done_b} : {po_a, busy_a, done_a};
  endfunction

  // Waits (bounded) until both instances are idle.
  task automatic wait_idle();
    int n = 0;
    while ((busy_a || busy_b) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", (busy_a || busy_b) ? 1 : 0, 0);
    @(negedge clk);
  endtask

  // Drives a one-cycle start; returns at the negedge of cycle k+1.
  task automatic pulse_start(input logic [3:0] c);
    @(negedge clk);
    start = 1'b1;
    count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Expected pulse_out at cycle t after the start edge (t>=1).
  function automatic bit exp_pulse(input int n, input int on, input int off, input int t);
    int p;
    p = t - 1;
    return (p / (on + off) < n) && (p % (on + off) < on);
  endfunction

  task automatic run_vec(input vec_t v);
    int on, off, rises, dones, bad_p, bad_b, bad_d;
    logic [2:0] o;
    logic prev;
    on = v.sel_b ? 2 : 4;
    off = v.sel_b ? 3 : 4;
    rises = 0; dones = 0; bad_p = 0; bad_b = 0; bad_d = 0; prev = 1'b0;
    wait_idle();
    pulse_start(v.cnt);
    for (int t = 1; t <= v.last + 4; t++) begin
      o = outs(v.sel_b);
      if (o[2] !== exp_pulse(int'(v.cnt), on, off, t)) bad_p++;
      if (o[1] !== (t <= v.last)) bad_b++;
      if (o[0] !== (t == v.last + 1)) bad_d++;
      if (o[2] && !prev) rises++;
      if (o[0]) dones++;
      prev = o[2];
      @(negedge clk);
    end
    check($sformatf("vec cnt=%0d pulse_err_cycles", v.cnt), bad_p, 0);
    check($sformatf("vec cnt=%0d busy_err_cycles", v.cnt), bad_b, 0);
    check($sformatf("vec cnt=%0d done_err_cycles", v.cnt), bad_d, 0);
    check($sformatf("vec cnt=%0d pulses", v.cnt), rises, int'(v.cnt));
    check($sformatf("vec cnt=%0d dones", v.cnt), dones, 1);
  endtask

  // Counts pulses and dones of instance A over a window of cycles.
  task automatic observe_a(input int cycles, output int rises, output int dones);
    logic prev = po_a;
    rises = 0; dones = 0;
    for (int t = 0; t < cycles; t++) begin
      if (po_a && !prev) rises++;
      if (done_a) dones++;
      prev = po_a;
      @(negedge clk);
    end
  endtask

  initial begin
    int r, d, zeros;
    vecs[0] = '{cnt: 4'd1,  sel_b: 1'b0, last: 4};
    vecs[1] = '{cnt: 4'd3,  sel_b: 1'b1, last: 12};
    vecs[2] = '{cnt: 4'd0,  sel_b: 1'b0, last: 0};
    vecs[3] = '{cnt: 4'd2,  sel_b: 1'b0, last: 12};
    vecs[4] = '{cnt: 4'd15, sel_b: 1'b1, last: 72};
    vecs[5] = '{cnt: 4'd5,  sel_b: 1'b1, last: 22};

    // Power-up reset.
    repeat (3) @(negedge clk);
    check("por_outs_a", int'({po_a, busy_a, done_a}), 0);
    check("por_outs_b", int'({po_b, busy_b, done_b}), 0);
    reset = 1'b1;

    // Reset with prior activity: outputs clear immediately and stay clear.
    pulse_start(4'd3);
    repeat ($urandom_range(2, 9)) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_async_a", int'({po_a, busy_a, done_a}), 0);
    check("rst_async_b", int'({po_b, busy_b, done_b}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    zeros = 0;
    for (int t = 0; t < 8; t++) begin
      if ({po_a, busy_a, done_a, po_b, busy_b, done_b} != 6'b0) zeros++;
      @(negedge clk);
    end
    check("rst_stays_low_cycles", zeros, 0);

    // Table-driven bursts.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // start during busy: second start in the middle of the first pulse.
    wait_idle();
    pulse_start(4'd2);
    start = 1'b1;
    count = 4'd5;
    @(negedge clk);
    start = 1'b0;
    observe_a(40, r, d);
    check("busy_start_pulses", r + 1, 2);  // first rise happened before window
    check("busy_start_dones", d, 1);

    // Reset during pulse 2 of a count=3 burst on A (pulse 2 is cycles 9..12).
    wait_idle();
    pulse_start(4'd3);
    repeat (9) @(negedge clk);  // now at cycle 10
    check("pre_rst_pulse_a", int'(po_a), 1);
    reset = 1'b0;
    #1;
    check("midburst_rst_outs", int'({po_a, busy_a, done_a}), 0);
    @(negedge clk);
    reset = 1'b1;
    observe_a(30, r, d);
    check("post_rst_pulses", r, 0);
    check("post_rst_dones", d, 0);

    // After release: a full count=15 burst on A.
    pulse_start(4'd15);
    observe_a(130, r, d);
    check("post_rst_15_pulses", r + 1, 15);
    check("post_rst_15_dones", d, 1);

    // Back-to-back: start pulsed in the done cycle (cycle 5 for count=1 on A).
    wait_idle();
    pulse_start(4'd1);
    repeat (4) @(negedge clk);  // now at cycle 5
    check("b2b_done_cycle", int'({po_a, busy_a, done_a}), 3'b001);
    start = 1'b1;
    count = 4'd1;
    @(negedge clk);            // cycle 6
    start = 1'b0;
    check("b2b_next_pulse", int'({po_a, busy_a, done_a}), 3'b110);
    repeat (3) @(negedge clk); // cycle 9
    check("b2b_pulse_end", int'({po_a, busy_a, done_a}), 3'b110);
    @(negedge clk);            // cycle 10
    check("b2b_second_done", int'({po_a, busy_a, done_a}), 3'b001);

    // start held high: only the first accepted edge produces a burst.
    wait_idle();
    @(negedge clk);
    start = 1'b1;
    count = 4'd1;
    @(negedge clk);
    observe_a(20, r, d);
    start = 1'b0;
    check("held_start_pulses", r + 1, 1);
    check("held_start_dones", d, 1);
    observe_a(20, r, d);
    check("held_release_pulses", r, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
